regfile_write_arbiter: RTL
==========================

// Module: regfile_write_arbiter
// PURPOSE
// - Shares the register file's single write port between three producers: ALU writeback,
//   memory load return and label-set unit.
// - Arbitrates round-robin and drives the register file's rd / write_data / reg_write /
//   label_write inputs from a registered stage.
// - Keeps a pending-write scoreboard for general regs a0-a3, v0, c0 and label regs l0-l5.
//   Issue logic queries it for read-after-write hazards on rs1/rs2.
// PARAMETERS
// - NREQ    3  number of write requesters (index 0=ALU, 1=LOAD, 2=LABEL)
// - NREGS   6  implemented registers per bank; rd >= NREGS is illegal
// - DW      8  data width
// PORTS
// - clk             in   1        clock, rising edge
// - rst_n           in   1        async reset, active low
// - req_valid       in   NREQ     requester has a write pending
// - req_ready       out  NREQ     one-hot grant; transfer when valid&ready
// - req_rd          in   3*NREQ   destination index per requester, packed [3i+:3]
// - req_data        in   DW*NREQ  write data per requester, packed [DW*i+:DW]
// - req_label       in   NREQ     1 = target label bank, 0 = general bank
// - rf_rd           out  3        to register file rd
// - rf_write_data   out  DW       to register file write_data
// - rf_reg_write    out  1        general-bank write strobe
// - rf_label_write  out  1        label-bank write strobe
// - claim_valid     in   1        issue stage reserves a destination
// - claim_rd        in   3        reserved index
// - claim_label     in   1        reserved bank
// - chk_rs1         in   3        hazard query source 1
// - chk_rs2         in   3        hazard query source 2
// - chk_label       in   1        bank of the query
// - hazard          out  1        rs1 or rs2 has a pending write (combinational)
// - illegal_wr      out  1        one-cycle pulse: granted write had rd >= NREGS
// BEHAVIOUR
// - Clock and reset
//   - Single clock domain.
//   - Reset is asynchronous and active low.
//   - On reset: all rf_* outputs 0, illegal_wr 0, RR pointer 0, scoreboard all clear.
// - Arbitration
//   - req_ready is combinational: at most one bit set.
//   - Grant goes to the first valid requester at or after the RR pointer, wrapping NREQ-1 -> 0.
//   - If no requester is valid, req_ready = 0.
//   - After a grant to index g, the pointer becomes (g+1) mod NREQ. Otherwise it holds.
//   - A requester holding valid is granted within NREQ cycles (no starvation).
// - Write stage (latency 1)
//   - The grant at edge N drives rf_rd / rf_write_data from edge N.
//   - Exactly one strobe is asserted for one cycle, selected by req_label:
//     rf_reg_write for the general bank, rf_label_write for the label bank.
//   - rf_reg_write and rf_label_write are never both 1.
//   - With no grant, both strobes are 0 and rf_rd / rf_write_data hold their last value.
//   - Back-to-back grants produce one write per cycle; throughput is 1 write/cycle.
//   - Illegal rd (6 or 7): the request is still granted and consumed.
//     No strobe is asserted, illegal_wr = 1 for one cycle, and the scoreboard is untouched.
// - Scoreboard: 2 banks x NREGS bits
//   - claim_valid with legal claim_rd sets the bit at the clock edge.
//   - Illegal claim_rd is ignored.
//   - A bit clears in the cycle its strobe is asserted (the write reaches the register file).
//   - Set and clear of the same bit in the same cycle: set wins (the newer claim survives).
//   - Claiming an already-set bit leaves it set. There is no counting; one write clears it.
//   - hazard = sb[chk_label][chk_rs1] | sb[chk_label][chk_rs2].
//   - Out-of-range query indices read as 0.
//   - hazard reflects the scoreboard's registered state; there is no forwarding of
//     same-cycle claims.
// - Reset mid-operation: an in-flight strobe is dropped, the pointer returns to 0,
//   and all claims are lost.
// STRUCTURE
// - Shared package regfile_pkg:
//   - localparams NREGS and DW
//   - typedef reg_idx_t = logic [2:0]
//   - enum req_id_e {REQ_ALU, REQ_LOAD, REQ_LABEL}
//   - enum bank_e {BANK_GEN, BANK_LABEL}
// - One sub-module rr_arbiter (NREQ-wide, valid -> one-hot grant, pointer update on grant).
// - Scoreboard, write stage and hazard logic stay in this module.
// TESTING
// - Reset: assert rst_n=0 mid-stream with all valid -> strobes 0, illegal_wr 0,
//   hazard 0 for any query.
// - Single ALU write: valid[0], rd=2, data=8'h5A, label=0 -> next cycle rf_rd=2,
//   data 5A, rf_reg_write=1 for exactly 1 cycle.
// - All three valid continuously from pointer 0 -> grants 0,1,2,0,1,2.
//   Label requester rd=4 produces rf_label_write only.
// - Claim rd=3 bank GEN, query rs1=3 -> hazard=1 from next cycle.
//   A LOAD write to rd=3 clears it: hazard=0 the cycle after the strobe.
// - Same-cycle claim of rd=1 and a write commit to rd=1 -> bit remains set, hazard=1.
// - Write rd=7 -> no strobe, illegal_wr pulses once, scoreboard unchanged, pointer advances.

Source files
------------

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared types and constants for the register-file write path.
//               It holds the bank and requester enums, the register index type,
//               and helpers that turn an index into a legal one-hot mask.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int NREGS = 6;   // implemented registers per bank
    localparam int DW    = 8;   // data width

    typedef logic [2:0] reg_idx_t;

    typedef enum logic [1:0] {
        REQ_ALU   = 2'd0,
        REQ_LOAD  = 2'd1,
        REQ_LABEL = 2'd2
    } req_id_e;

    typedef enum logic {
        BANK_GEN   = 1'b0,
        BANK_LABEL = 1'b1
    } bank_e;

    // One-hot mask of a register index. Indices >= NREGS give an all-zero
    // mask, so illegal indices never touch or read the scoreboard.
    function automatic logic [NREGS-1:0] idx_mask(input reg_idx_t idx);
        logic [NREGS-1:0] m;
        m = '0;
        for (int i = 0; i < NREGS; i++) begin
            m[i] = (idx == reg_idx_t'(i));
        end
        return m;
    endfunction

    function automatic logic rd_legal(input reg_idx_t idx);
        return idx < reg_idx_t'(NREGS);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter. Combinational one-hot grant to the first
//               valid requester at or after the pointer, wrapping around.
//               The pointer moves past the winner on every grant.
// Ports       : clk, rst_n (async, active low)
//               valid[NREQ]  request vector
//               grant[NREQ]  one-hot grant (zero when nothing is valid)
//               grant_any    some requester was granted this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] valid,
    output logic [NREQ-1:0] grant,
    output logic            grant_any
);

    localparam int            c_PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [c_PW-1:0] c_LAST = c_PW'(NREQ - 1);

    logic [c_PW-1:0] r_ptr;
    logic [c_PW-1:0] w_gidx;
    logic [c_PW:0]   w_idx;

    // Scan NREQ positions starting at the pointer; the extra bit in w_idx
    // lets ptr+k exceed NREQ-1 before folding back into range.
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        w_gidx    = r_ptr;
        w_idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = {1'b0, r_ptr} + (c_PW+1)'(k);
            if (w_idx >= (c_PW+1)'(NREQ)) begin
                w_idx = w_idx - (c_PW+1)'(NREQ);
            end
            if (!grant_any && valid[w_idx[c_PW-1:0]]) begin
                grant_any = 1'b1;
                w_gidx    = w_idx[c_PW-1:0];
            end
        end
        if (grant_any) begin
            grant[w_gidx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (grant_any) begin
            r_ptr <= (w_gidx == c_LAST) ? '0 : w_gidx + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_arbiter
// Description : Shares the register file's single write port between the
//               ALU, load-return and label-set producers. The round-robin
//               winner is registered onto rf_* one cycle later. A pending-write
//               scoreboard (general and label banks) answers RAW hazard queries.
// Ports       : clk, rst_n (async, active low)
//               req_valid/req_ready/req_rd/req_data/req_label  requesters
//               rf_rd/rf_write_data/rf_reg_write/rf_label_write  regfile side
//               claim_valid/claim_rd/claim_label   destination reservation
//               chk_rs1/chk_rs2/chk_label/hazard   hazard query
//               illegal_wr  pulse when a granted write had rd >= NREGS
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [3*NREQ-1:0] req_rd,
    input  logic [DW*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_label,
    output logic [2:0]        rf_rd,
    output logic [DW-1:0]     rf_write_data,
    output logic              rf_reg_write,
    output logic              rf_label_write,
    input  logic              claim_valid,
    input  logic [2:0]        claim_rd,
    input  logic              claim_label,
    input  logic [2:0]        chk_rs1,
    input  logic [2:0]        chk_rs2,
    input  logic              chk_label,
    output logic              hazard,
    output logic              illegal_wr
);

    logic [NREQ-1:0]  w_grant;
    logic             w_grant_any;
    reg_idx_t         w_sel_rd;
    logic [DW-1:0]    w_sel_data;
    logic             w_sel_label;
    logic             w_sel_legal;

    reg_idx_t         r_rf_rd;
    logic [DW-1:0]    r_rf_write_data;
    logic             r_rf_reg_write;
    logic             r_rf_label_write;
    logic             r_illegal_wr;

    logic [NREGS-1:0] r_sb_gen;
    logic [NREGS-1:0] r_sb_lbl;
    logic [NREGS-1:0] w_set_gen;
    logic [NREGS-1:0] w_set_lbl;
    logic [NREGS-1:0] w_clr_gen;
    logic [NREGS-1:0] w_clr_lbl;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     (req_valid),
        .grant     (w_grant),
        .grant_any (w_grant_any)
    );

    assign req_ready = w_grant;

    // One-hot mux of the granted requester's fields.
    always_comb begin
        w_sel_rd    = '0;
        w_sel_data  = '0;
        w_sel_label = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_sel_rd    = req_rd[3*i +: 3];
                w_sel_data  = req_data[DW*i +: DW];
                w_sel_label = req_label[i];
            end
        end
    end

    assign w_sel_legal = rd_legal(w_sel_rd);

    // Write stage. An illegal rd is still consumed (and its rd/data shown on
    // the port) but raises illegal_wr instead of a strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rf_rd          <= '0;
            r_rf_write_data  <= '0;
            r_rf_reg_write   <= 1'b0;
            r_rf_label_write <= 1'b0;
            r_illegal_wr     <= 1'b0;
        end else begin
            r_rf_reg_write   <= 1'b0;
            r_rf_label_write <= 1'b0;
            r_illegal_wr     <= 1'b0;
            if (w_grant_any) begin
                r_rf_rd          <= w_sel_rd;
                r_rf_write_data  <= w_sel_data;
                r_rf_reg_write   <= w_sel_legal && (bank_e'(w_sel_label) == BANK_GEN);
                r_rf_label_write <= w_sel_legal && (bank_e'(w_sel_label) == BANK_LABEL);
                r_illegal_wr     <= !w_sel_legal;
            end
        end
    end

    assign rf_rd          = r_rf_rd;
    assign rf_write_data  = r_rf_write_data;
    assign rf_reg_write   = r_rf_reg_write;
    assign rf_label_write = r_rf_label_write;
    assign illegal_wr     = r_illegal_wr;

    // Scoreboard. A bit clears at the end of the cycle its strobe is high,
    // i.e. when the register file actually captures the write. A claim in
    // that same cycle is newer than the write, so set is applied last.
    assign w_set_gen = (claim_valid && bank_e'(claim_label) == BANK_GEN)   ? idx_mask(claim_rd) : '0;
    assign w_set_lbl = (claim_valid && bank_e'(claim_label) == BANK_LABEL) ? idx_mask(claim_rd) : '0;
    assign w_clr_gen = r_rf_reg_write   ? idx_mask(r_rf_rd) : '0;
    assign w_clr_lbl = r_rf_label_write ? idx_mask(r_rf_rd) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sb_gen <= '0;
            r_sb_lbl <= '0;
        end else begin
            r_sb_gen <= (r_sb_gen & ~w_clr_gen) | w_set_gen;
            r_sb_lbl <= (r_sb_lbl & ~w_clr_lbl) | w_set_lbl;
        end
    end

    // Out-of-range query indices produce an empty mask and so read as 0.
    assign hazard = |((chk_label ? r_sb_lbl : r_sb_gen) &
                      (idx_mask(chk_rs1) | idx_mask(chk_rs2)));

endmodule
`default_nettype wire
